// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator: internal h/v counters drive registered
// sync, display-enable and an {R,G,B} pattern pixel selected once per frame.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CH_W       = 1,
  parameter int SYNC_POL   = 0,
  parameter int CHECK_LOG2 = 5,
  parameter int MOVE_W     = 16
) (
  input  logic                clk_25,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  output logic [3*CH_W-1:0]   pixel,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                display_en,
  output logic                frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int CW      = ((HW > PW) ? HW : PW) + 1;
  localparam int PIX_W   = 3 * CH_W;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BCW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0]  H_VIS    = HW'(H_ACTIVE);
  localparam logic [VW-1:0]  V_VIS    = VW'(V_ACTIVE);
  localparam logic [HW-1:0]  HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]  HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0]  VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]  VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [PW-1:0]  POS_LAST = PW'(H_ACTIVE - 1);
  localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);
  localparam logic           SYNC_ACT = (SYNC_POL != 0);

  function automatic logic [PIX_W-1:0] expand_rgb(input logic [2:0] rgb);
    return {{CH_W{rgb[2]}}, {CH_W{rgb[1]}}, {CH_W{rgb[0]}}};
  endfunction

  function automatic logic [2:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'b111;
      3'd1:    return 3'b110;
      3'd2:    return 3'b011;
      3'd3:    return 3'b010;
      3'd4:    return 3'b101;
      3'd5:    return 3'b100;
      3'd6:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  logic [HW-1:0]  hcnt;
  logic [VW-1:0]  vcnt;
  logic [1:0]     mode_q;
  logic [PW-1:0]  pos;
  logic [BCW-1:0] bar_cnt;
  logic [2:0]     bar_idx;

  logic             h_wrap, v_wrap, at_origin, visible_p0, hs_act_p0, vs_act_p0;
  logic             in_bar_p0;
  logic [1:0]       mode_eff_p0;
  logic [PW-1:0]    pos_nxt;
  logic [CW-1:0]    x_ext, pos_ext;
  logic [2:0]       rgb_p0;
  logic [PIX_W-1:0] pixel_p0;

  // stage p0: decode current counter state into next output values
  assign h_wrap     = (hcnt == H_LAST);
  assign v_wrap     = (vcnt == V_LAST);
  assign at_origin  = (hcnt == '0) && (vcnt == '0);
  assign visible_p0 = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign hs_act_p0  = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
  assign vs_act_p0  = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);

  // the origin pixel already belongs to the new frame, so it sees the mode and pos being latched
  assign mode_eff_p0 = at_origin ? mode : mode_q;
  assign pos_nxt     = (at_origin && mode == 2'd3) ? ((pos == POS_LAST) ? '0 : pos + 1'b1) : pos;

  assign x_ext     = CW'(hcnt);
  assign pos_ext   = CW'(pos_nxt);
  assign in_bar_p0 = (x_ext >= pos_ext) && (x_ext < pos_ext + CW'(MOVE_W));

  always_comb begin
    rgb_p0 = 3'b000;
    if (visible_p0) begin
      case (mode_eff_p0)
        2'd0:    rgb_p0 = 3'b111;
        2'd1:    rgb_p0 = bar_colour(bar_idx);
        2'd2:    rgb_p0 = {3{hcnt[CHECK_LOG2] ^ vcnt[CHECK_LOG2]}};
        default: rgb_p0 = {3{in_bar_p0}};
      endcase
    end
    pixel_p0 = expand_rgb(rgb_p0);
  end

  // stage p1: counters advance, outputs register the p0 decode
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      mode_q      <= 2'd0;
      pos         <= '0;
      bar_cnt     <= '0;
      bar_idx     <= 3'd0;
      pixel       <= '0;
      display_en  <= 1'b0;
      frame_start <= 1'b0;
      hsync_out   <= ~SYNC_ACT;
      vsync_out   <= ~SYNC_ACT;
    end else begin
      hcnt <= h_wrap ? '0 : hcnt + 1'b1;
      if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + 1'b1;
      if (at_origin) mode_q <= mode;
      pos <= pos_nxt;

      // bar tracker follows hcnt; the last bar absorbs any remainder pixels
      if (h_wrap) begin
        bar_cnt <= '0;
        bar_idx <= 3'd0;
      end else if (bar_cnt == BAR_LAST) begin
        bar_cnt <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + 1'b1;
      end

      pixel       <= pixel_p0;
      display_en  <= visible_p0;
      frame_start <= at_origin;
      hsync_out   <= hs_act_p0 ? SYNC_ACT : ~SYNC_ACT;
      vsync_out   <= vs_act_p0 ? SYNC_ACT : ~SYNC_ACT;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized-mode bench for vga_pattern_gen on a shrunk raster, every output
// compared each cycle against a frame-level arithmetic model.
module tb_vga_pattern_gen;
  localparam int HA = 42, HFP = 4, HSY = 6, HBP = 4;
  localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 1;
  localparam int CHW = 2, SPOL = 0, CL2 = 2, MW = 16;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int BW = HA / 8;

  logic              clk_25 = 1'b0;
  logic              rst_n  = 1'b1;
  logic [1:0]        mode   = 2'd0;
  logic [3*CHW-1:0]  pixel;
  logic              hsync_out, vsync_out, display_en, frame_start;

  int checks = 0;
  int failures = 0;

  int mh = 0, mv = 0, mmq = 0, mpos = 0;
  int e_pix, e_de, e_fs, e_hs, e_vs;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .CH_W(CHW), .SYNC_POL(SPOL), .CHECK_LOG2(CL2), .MOVE_W(MW)
  ) dut (
    .clk_25(clk_25), .rst_n(rst_n), .mode(mode), .pixel(pixel),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .display_en(display_en), .frame_start(frame_start)
  );

  always #5 clk_25 = ~clk_25;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t (h=%0d v=%0d mode_q=%0d pos=%0d): got=%0h expected=%0h",
               tag, $time, mh, mv, mmq, mpos, got, exp);
    end
  endtask

  function automatic int rgb_of(int x, int y, int m, int p);
    int b;
    case (m)
      0: return 7;
      1: begin
        b = x / BW;
        if (b > 7) b = 7;
        case (b)
          0: return 3'b111; 1: return 3'b110; 2: return 3'b011; 3: return 3'b010;
          4: return 3'b101; 5: return 3'b100; 6: return 3'b001; default: return 3'b000;
        endcase
      end
      2: return (((x >> CL2) ^ (y >> CL2)) & 1) ? 7 : 0;
      default: return (x >= p && x < p + MW) ? 7 : 0;
    endcase
  endfunction

  function automatic int expand(int rgb);
    int r = 0;
    for (int c = 2; c >= 0; c--) begin
      r = r << CHW;
      if ((rgb >> c) & 1) r = r | ((1 << CHW) - 1);
    end
    return r;
  endfunction

  task automatic set_reset_expect();
    mh = 0; mv = 0; mmq = 0; mpos = 0;
    e_pix = 0; e_de = 0; e_fs = 0; e_hs = 1 - SPOL; e_vs = 1 - SPOL;
  endtask

  task automatic compare_all();
    check("pixel", 32'(pixel), 32'(e_pix));
    check("display_en", 32'(display_en), 32'(e_de));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("hsync", 32'(hsync_out), 32'(e_hs));
    check("vsync", 32'(vsync_out), 32'(e_vs));
  endtask

  task automatic step();
    @(posedge clk_25);
    if (!rst_n) begin
      set_reset_expect();
    end else begin
      if (mh == 0 && mv == 0) begin
        mmq = int'(mode);
        if (mmq == 3) mpos = (mpos + 1) % HA;
      end
      e_fs  = (mh == 0 && mv == 0);
      e_de  = (mh < HA && mv < VA);
      e_pix = e_de ? expand(rgb_of(mh, mv, mmq, mpos)) : 0;
      e_hs  = (mh >= HA + HFP && mh < HA + HFP + HSY) ? SPOL : 1 - SPOL;
      e_vs  = (mv >= VA + VFP && mv < VA + VFP + VSY) ? SPOL : 1 - SPOL;
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end
    #1;
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    // power-up reset, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    set_reset_expect();
    compare_all();
    run(3);
    @(negedge clk_25) rst_n = 1'b1;
    run(1);
    check("first_frame_start", 32'(frame_start), 32'd1);

    run(FRAME + 37);

    for (int s = 0; s < 8; s++) begin
      mode = 2'($urandom_range(0, 3));
      run($urandom_range(100, 1500));
    end

    // long moving-bar stretch covers clipping at the right edge and pos wrap
    mode = 2'd3;
    run(FRAME * (HA + 4));

    // switch mid-frame: bar must persist to frame end, then colour bars
    run(FRAME / 2 - 5);
    mode = 2'd1;
    run(FRAME * 2);

    mode = 2'd2;
    run(FRAME + 11);

    // asynchronous reset inside the visible area
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (mh == 20 && mv == 5) found = 1'b1;
    end
    check("reset_point_reached", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    set_reset_expect();
    compare_all();
    run(2);
    mode = 2'($urandom_range(0, 3));
    @(negedge clk_25) rst_n = 1'b1;
    run(1);
    check("frame_start_after_release", 32'(frame_start), 32'd1);
    run(FRAME + 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
